// File: rtl/sram_pkg.sv
// Shared SRAM geometry constants and the write-port arbiter state encoding.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 16;
  localparam int unsigned SRAM_DATA_W = 128;

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_t;

endpackage

// File: rtl/sram_wport_arbiter_if.sv
// Requester beat bus plus the SRAM write-port outputs driven by the arbiter.
interface sram_wport_arbiter_if
  import sram_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = SRAM_ADDR_W,
  parameter int unsigned DATA_W  = SRAM_DATA_W
);

  localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      WE;
  logic [ADDR_W-1:0]         WriteAddress;
  logic [DATA_W-1:0]         WriteBus;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;

  modport master (
    output req_valid, req_last, req_addr, req_data,
    input  req_ready, WE, WriteAddress, WriteBus, grant_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_addr, req_data,
    output req_ready, WE, WriteAddress, WriteBus, grant_id, busy
  );

endinterface

// File: rtl/sram_wport_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit after rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    idx    = '0;
    // Walk from farthest to nearest so the slot right after rr_ptr is written last and wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) winner = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/sram_wport_arbiter.sv
// Round-robin owner of one SRAM write port; grants are locked for a whole burst
// (capped at MAX_BURST beats) and every accepted beat is written one cycle later.
module sram_wport_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned MAX_BURST = 16
) (
  input logic                 clock,
  input logic                 reset_n,
  sram_wport_arbiter_if.slave bus
);

  localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_t        state_q, state_d;
  logic [GID_W-1:0]  grant_q, grant_d;
  logic [GID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]  winner;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              any_req;
  logic              accept;
  logic              release_now;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (GID_W)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .rr_ptr(rr_ptr_q),
    .winner(winner),
    .any   (any_req)
  );

  assign accept      = (state_q == OWN) && bus.req_valid[grant_q];
  // A forced release at the cap leaves the requester's burst open; it re-arbitrates.
  assign release_now = accept && (bus.req_last[grant_q] || (beat_cnt_q == LAST_CNT));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    we_d       = accept;
    addr_d     = addr_q;
    data_d     = data_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = OWN;
          grant_d    = winner;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          addr_d     = bus.req_addr[int'(grant_q) * ADDR_W +: ADDR_W];
          data_d     = bus.req_data[int'(grant_q) * DATA_W +: DATA_W];
        end
        if (release_now) begin
          state_d  = IDLE;
          rr_ptr_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= GID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == OWN) bus.req_ready[grant_q] = 1'b1;
  end

  assign bus.WE           = we_q;
  assign bus.WriteAddress = addr_q;
  assign bus.WriteBus     = data_q;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = (state_q == OWN);

endmodule

// File: tb/tb_sram_wport_arbiter.sv
// Self-checking bench: per-requester beat queues drive the arbiter; writes are
// compared against a transaction-level round-robin schedule model.
module tb_sram_wport_arbiter;
  import sram_pkg::*;

  localparam int NREQ = 4;
  localparam int MAXB = 16;
  localparam int AW   = SRAM_ADDR_W;
  localparam int DW   = SRAM_DATA_W;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int            req;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  sram_wport_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_wport_arbiter #(
    .NUM_REQ  (NREQ),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_BURST(MAXB)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  beat_t         rq [NREQ][$];
  int            start_cyc [NREQ];
  bit            paused [NREQ];
  bit            acc [NREQ];
  wr_t           wlog [$];
  wr_t           exp_q [$];
  logic [DW-1:0] mem [int];
  int            cyc;
  int            n_tests;
  int            n_fail;

  function automatic bit wr_eq(wr_t a, wr_t b);
    return (a.req == b.req) && (a.addr === b.addr) && (a.data === b.data) && (a.cyc == b.cyc);
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += rq[i].size();
    return n;
  endfunction

  task automatic drive();
    bit v;
    for (int i = 0; i < NREQ; i++) begin
      v = (rq[i].size() > 0) && !paused[i] && (cyc >= start_cyc[i]);
      bus.req_valid[i] = v;
      if (v) begin
        bus.req_addr[i*AW +: AW] = rq[i][0].addr;
        bus.req_data[i*DW +: DW] = rq[i][0].data;
        bus.req_last[i]          = rq[i][0].last;
      end else begin
        bus.req_addr[i*AW +: AW] = AW'($urandom);
        bus.req_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        bus.req_last[i]          = 1'($urandom_range(0, 1));
      end
      acc[i] = v && (bus.req_ready[i] === 1'b1);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    if (bus.WE === 1'b1) begin
      wlog.push_back('{req: int'(bus.grant_id), addr: bus.WriteAddress, data: bus.WriteBus,
                       cyc: cyc});
      mem[int'(bus.WriteAddress)] = bus.WriteBus;
    end
    drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rq[i].delete();
      paused[i]    = 1'b0;
      acc[i]       = 1'b0;
      start_cyc[i] = 0;
    end
    drive();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    wlog.delete();
    mem.delete();
  endtask

  task automatic load_burst(int r, int n, int base);
    for (int k = 0; k < n; k++)
      rq[r].push_back('{addr: AW'(base + k), data: {$urandom, $urandom, $urandom, $urandom},
                        last: (k == n - 1)});
  endtask

  // Schedule model: each grant goes to the next requester after the previous owner that
  // is already presenting beats; it serves up to the burst end or MAXB beats, the n-th beat
  // is written n cycles after the decision, and the next decision follows one cycle later.
  task automatic build_expected(int c0);
    beat_t mq [NREQ][$];
    beat_t b;
    int    rr, s, w, n, idx;
    bit    done;
    rr = NREQ - 1;
    s  = c0 + 1;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
    while (1) begin
      n = 0;
      for (int i = 0; i < NREQ; i++) n += mq[i].size();
      if (n == 0) break;
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (rr + k) % NREQ;
        if (w < 0 && mq[idx].size() > 0 && start_cyc[idx] < s) w = idx;
      end
      if (w < 0) begin
        s++;
        continue;
      end
      n    = 0;
      done = 1'b0;
      while (!done) begin
        b = mq[w].pop_front();
        n++;
        exp_q.push_back('{req: w, addr: b.addr, data: b.data, cyc: s + n});
        done = b.last || (n == MAXB) || (mq[w].size() == 0);
      end
      rr = w;
      s += n + 1;
    end
  endtask

  task automatic run_queues(int maxc, string name);
    int n = 0;
    while (pending() > 0 && n < maxc) begin
      cycle();
      n++;
    end
    n_tests++;
    if (pending() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d beats still queued after %0d cycles, required 0",
               name, pending(), maxc);
    end
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.WE !== 1'b0) begin n_fail++; $display("FAIL reset WE: got %b, required 0", bus.WE); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, required 0", bus.busy); end
    n_tests++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL reset req_ready: got %b, required 0000", bus.req_ready); end
    n_tests++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset grant_id: got %0d, required 0", bus.grant_id); end
    n_tests++; if (bus.WriteAddress !== 16'h0) begin n_fail++; $display("FAIL reset WriteAddress: got %h, required 0", bus.WriteAddress); end
    n_tests++; if (bus.WriteBus !== 128'h0) begin n_fail++; $display("FAIL reset WriteBus: got %h, required 0", bus.WriteBus); end
  endtask

  task automatic test_single_beat();
    logic [DW-1:0] pat = {16{8'hA5}};
    logic [DW-1:0] got;
    do_reset();
    rq[2].push_back('{addr: 16'h0010, data: pat, last: 1'b1});
    start_cyc[2] = cyc + 1;
    cycle();
    cycle();
    n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single req_ready: got %b, required 0100", bus.req_ready); end
    n_tests++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL single grant: got busy %b id %0d, required busy 1 id 2", bus.busy, bus.grant_id); end
    cycle();
    n_tests++; if (bus.WE !== 1'b1 || bus.WriteAddress !== 16'h0010) begin n_fail++; $display("FAIL single write: got WE %b addr %h, required WE 1 addr 0010", bus.WE, bus.WriteAddress); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single release: got busy %b, required 0", bus.busy); end
    got = mem.exists(16) ? mem[16] : '0;
    n_tests++; if (got !== pat) begin n_fail++; $display("FAIL single sram word 0x10: got %h, required %h", got, pat); end
    cycle();
    n_tests++; if (bus.WE !== 1'b0) begin n_fail++; $display("FAIL single no repeat: got WE %b, required 0", bus.WE); end
  endtask

  task automatic test_two_bursts();
    do_reset();
    load_burst(0, 3, 'h100);
    load_burst(1, 3, 'h200);
    start_cyc[0] = cyc + 1;
    start_cyc[1] = cyc + 1;
    build_expected(cyc + 1);
    run_queues(200, "two_bursts");
    n_tests++; if (wlog.size() != exp_q.size()) begin n_fail++; $display("FAIL two_bursts count: got %0d, required %0d", wlog.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < wlog.size(); k++) begin
      n_tests++;
      if (!wr_eq(wlog[k], exp_q[k])) begin
        n_fail++;
        $display("FAIL two_bursts write %0d: got req %0d addr %h cyc %0d, required req %0d addr %h cyc %0d",
                 k, wlog[k].req, wlog[k].addr, wlog[k].cyc, exp_q[k].req, exp_q[k].addr, exp_q[k].cyc);
      end
    end
    if (wlog.size() >= 4) begin
      n_tests++;
      if (wlog[3].cyc - wlog[2].cyc != 2) begin n_fail++; $display("FAIL two_bursts bubble: got gap %0d, required 2", wlog[3].cyc - wlog[2].cyc); end
    end
  endtask

  task automatic test_all_single();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      load_burst(i, 1, 'h10 * i);
      load_burst(i, 1, 'h10 * i + 1);
      start_cyc[i] = cyc + 1;
    end
    build_expected(cyc + 1);
    run_queues(200, "all_single");
    n_tests++; if (wlog.size() != exp_q.size()) begin n_fail++; $display("FAIL all_single count: got %0d, required %0d", wlog.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < wlog.size(); k++) begin
      n_tests++;
      if (!wr_eq(wlog[k], exp_q[k])) begin
        n_fail++;
        $display("FAIL all_single write %0d: got req %0d addr %h cyc %0d, required req %0d addr %h cyc %0d",
                 k, wlog[k].req, wlog[k].addr, wlog[k].cyc, exp_q[k].req, exp_q[k].addr, exp_q[k].cyc);
      end
    end
    for (int k = 0; k < 6 && k + 1 < wlog.size(); k++) begin
      n_tests++;
      if (wlog[k].req != k % NREQ || wlog[k+1].cyc - wlog[k].cyc != 2) begin
        n_fail++;
        $display("FAIL all_single order %0d: got id %0d gap %0d, required id %0d gap 2",
                 k, wlog[k].req, wlog[k+1].cyc - wlog[k].cyc, k % NREQ);
      end
    end
  endtask

  task automatic test_forced_release();
    int n3 = 0;
    do_reset();
    load_burst(3, 20, 'h500);
    load_burst(1, 3, 'h600);
    start_cyc[3] = cyc + 1;
    start_cyc[1] = cyc + 3;
    build_expected(cyc + 1);
    run_queues(300, "forced_release");
    n_tests++; if (wlog.size() != exp_q.size()) begin n_fail++; $display("FAIL forced_release count: got %0d, required %0d", wlog.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < wlog.size(); k++) begin
      n_tests++;
      if (!wr_eq(wlog[k], exp_q[k])) begin
        n_fail++;
        $display("FAIL forced_release write %0d: got req %0d addr %h cyc %0d, required req %0d addr %h cyc %0d",
                 k, wlog[k].req, wlog[k].addr, wlog[k].cyc, exp_q[k].req, exp_q[k].addr, exp_q[k].cyc);
      end
    end
    for (int k = 0; k < wlog.size(); k++) begin
      if (wlog[k].req == 3) begin
        n_tests++;
        if (wlog[k].addr !== AW'('h500 + n3)) begin n_fail++; $display("FAIL forced_release seq %0d: got addr %h, required %h", n3, wlog[k].addr, AW'('h500 + n3)); end
        n3++;
      end
    end
    n_tests++; if (n3 != 20) begin n_fail++; $display("FAIL forced_release total from 3: got %0d, required 20", n3); end
    if (wlog.size() > 16) begin
      n_tests++;
      if (wlog[16].req != 1) begin n_fail++; $display("FAIL forced_release handover: got id %0d, required 1", wlog[16].req); end
    end
  endtask

  task automatic test_valid_gap();
    beat_t s2 [$];
    beat_t s0 [$];
    beat_t e;
    int    er;
    do_reset();
    load_burst(2, 4, 'h300);
    s2 = rq[2];
    start_cyc[2] = cyc + 1;
    repeat (3) cycle();
    paused[2] = 1'b1;
    load_burst(0, 1, 'h400);
    s0 = rq[0];
    start_cyc[0] = cyc + 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_tests++;
      if (bus.WE !== 1'b0 || bus.busy !== 1'b1 || bus.grant_id !== 2'd2 || bus.req_ready !== 4'b0100) begin
        n_fail++;
        $display("FAIL valid_gap hold %0d: got WE %b busy %b id %0d ready %b, required WE 0 busy 1 id 2 ready 0100",
                 i, bus.WE, bus.busy, bus.grant_id, bus.req_ready);
      end
    end
    paused[2] = 1'b0;
    drive();
    run_queues(200, "valid_gap");
    n_tests++; if (wlog.size() != 5) begin n_fail++; $display("FAIL valid_gap count: got %0d, required 5", wlog.size()); end
    for (int k = 0; k < 5 && k < wlog.size(); k++) begin
      e  = (k < 4) ? s2[k] : s0[0];
      er = (k < 4) ? 2 : 0;
      n_tests++;
      if (wlog[k].req != er || wlog[k].addr !== e.addr || wlog[k].data !== e.data) begin
        n_fail++;
        $display("FAIL valid_gap write %0d: got req %0d addr %h, required req %0d addr %h",
                 k, wlog[k].req, wlog[k].addr, er, e.addr);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    load_burst(1, 4, 'h900);
    start_cyc[1] = cyc + 1;
    repeat (4) cycle();
    n_tests++; if (bus.WE !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid pre: got WE %b busy %b, required 1 1", bus.WE, bus.busy); end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.WE !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid async: got WE %b busy %b ready %b, required 0 0 0000", bus.WE, bus.busy, bus.req_ready);
    end
    do_reset();
    load_burst(2, 2, 'h800);
    load_burst(0, 2, 'h700);
    start_cyc[0] = cyc + 1;
    start_cyc[2] = cyc + 1;
    build_expected(cyc + 1);
    run_queues(200, "reset_mid");
    n_tests++; if (wlog.size() != exp_q.size()) begin n_fail++; $display("FAIL reset_mid count: got %0d, required %0d", wlog.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < wlog.size(); k++) begin
      n_tests++;
      if (!wr_eq(wlog[k], exp_q[k])) begin
        n_fail++;
        $display("FAIL reset_mid write %0d: got req %0d addr %h cyc %0d, required req %0d addr %h cyc %0d",
                 k, wlog[k].req, wlog[k].addr, wlog[k].cyc, exp_q[k].req, exp_q[k].addr, exp_q[k].cyc);
      end
    end
    if (wlog.size() > 0) begin
      n_tests++;
      if (wlog[0].req != 0) begin n_fail++; $display("FAIL reset_mid first winner: got %0d, required 0", wlog[0].req); end
    end
  endtask

  task automatic test_random();
    int nb, len, base;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
        nb   = $urandom_range(0, 2);
        base = i * 'h1000;
        for (int b = 0; b < nb; b++) begin
          len = $urandom_range(1, 20);
          load_burst(i, len, base);
          base += len;
        end
        start_cyc[i] = cyc + 1 + $urandom_range(0, 6);
      end
      build_expected(cyc + 1);
      run_queues(2000, "random");
      n_tests++; if (wlog.size() != exp_q.size()) begin n_fail++; $display("FAIL random[%0d] count: got %0d, required %0d", it, wlog.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < wlog.size(); k++) begin
        n_tests++;
        if (!wr_eq(wlog[k], exp_q[k])) begin
          n_fail++;
          $display("FAIL random[%0d] write %0d: got req %0d addr %h cyc %0d, required req %0d addr %h cyc %0d",
                   it, k, wlog[k].req, wlog[k].addr, wlog[k].cyc, exp_q[k].req, exp_q[k].addr, exp_q[k].cyc);
        end
      end
    end
  endtask

  initial begin
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < NREQ; i++) begin
      paused[i]    = 1'b0;
      acc[i]       = 1'b0;
      start_cyc[i] = 0;
    end
    drive();
    test_reset();
    test_single_beat();
    test_two_bursts();
    test_all_single();
    test_forced_release();
    test_valid_gap();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
